// File: rtl/fifo_canal_if.sv
// Per-lane FIFO handshake bundle; the writer/reader side drives push/pop/data_in, the FIFO drives status and read data.
interface fifo_canal_if #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 2
);
    logic                  push;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  pop;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid_out;
    logic                  empty;
    logic                  full;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  error;

    modport master (
        output push, data_in, pop,
        input  data_out, valid_out, empty, full, almost_full, almost_empty, count, error
    );

    modport slave (
        input  push, data_in, pop,
        output data_out, valid_out, empty, full, almost_full, almost_empty, count, error
    );
endinterface

// File: rtl/fifo_canal.sv
// Single-clock per-lane FIFO: read data registered one edge after an accepted pop (valid_out strobe).
// Overflowing pushes are dropped, empty pops are refused; both set a sticky error; almost_full gives early backpressure.
module fifo_canal #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 2,
    parameter int AF_THRESH  = 3,
    parameter int AE_THRESH  = 1
) (
    input  logic         clk,
    input  logic         reset,
    fifo_canal_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   AF_C    = (ADDR_WIDTH+1)'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0]   AE_C    = (ADDR_WIDTH+1)'(AE_THRESH);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = 1;
    localparam logic [ADDR_WIDTH:0]   CNT_ONE = 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  valid_q, valid_d;
    logic                  error_q, error_d;

    logic full_w, empty_w, push_ok, pop_ok;

    assign full_w  = (count_q == DEPTH_C);
    assign empty_w = (count_q == '0);
    // A push into a full FIFO is still legal when a pop frees a slot on the same edge.
    assign push_ok = bus.push & (~full_w | bus.pop);
    assign pop_ok  = bus.pop & ~empty_w;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        data_out_d = data_out_q;
        valid_d    = 1'b0;
        error_d    = error_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop_ok) begin
            rd_ptr_d   = rd_ptr_q + PTR_ONE;
            data_out_d = mem_q[rd_ptr_q];
            valid_d    = 1'b1;
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + CNT_ONE;
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - CNT_ONE;
        end
        if ((bus.push && full_w && !bus.pop) || (bus.pop && empty_w)) begin
            error_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            error_q    <= error_d;
        end
    end

    // Storage is never cleared; only the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (!reset && push_ok) begin
            mem_q[wr_ptr_q] <= bus.data_in;
        end
    end

    assign bus.data_out     = data_out_q;
    assign bus.valid_out    = valid_q;
    assign bus.count        = count_q;
    assign bus.empty        = empty_w;
    assign bus.full         = full_w;
    assign bus.almost_full  = (count_q >= AF_C);
    assign bus.almost_empty = (count_q <= AE_C);
    assign bus.error        = error_q;
endmodule

// File: tb/tb_fifo_canal.sv
// Directed bench for fifo_canal with an occupancy model and a data scoreboard queue.
module tb_fifo_canal;
    localparam int DW = 6;
    localparam int AW = 2;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    logic [DW-1:0] sb[$];
    int            m_cnt;
    logic          m_err;
    logic [DW-1:0] m_dout;

    fifo_canal_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    fifo_canal #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_THRESH(3), .AE_THRESH(1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input logic exp_vld);
        chk("valid_out", 32'(bus.valid_out), 32'(exp_vld));
        chk("data_out", 32'(bus.data_out), 32'(m_dout));
        chk("count", 32'(bus.count), 32'(m_cnt));
        chk("empty", 32'(bus.empty), 32'(m_cnt == 0));
        chk("full", 32'(bus.full), 32'(m_cnt == 4));
        chk("almost_full", 32'(bus.almost_full), 32'(m_cnt >= 3));
        chk("almost_empty", 32'(bus.almost_empty), 32'(m_cnt <= 1));
        chk("error", 32'(bus.error), 32'(m_err));
    endtask

    task automatic do_reset(input int cycles, input logic p, input logic q);
        reset = 1'b1;
        bus.push = p;
        bus.pop = q;
        bus.data_in = 6'h3F;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
        end
        sb.delete();
        m_cnt = 0;
        m_err = 1'b0;
        m_dout = '0;
        chk_state(1'b0);
        reset = 1'b0;
        bus.push = 1'b0;
        bus.pop = 1'b0;
    endtask

    task automatic step(input logic p, input logic [DW-1:0] d, input logic q);
        logic pok, qok, vld;
        bus.push = p;
        bus.pop = q;
        bus.data_in = d;
        pok = p && (m_cnt != 4 || q);
        qok = q && (m_cnt != 0);
        vld = qok;
        if ((p && m_cnt == 4 && !q) || (q && m_cnt == 0)) m_err = 1'b1;
        if (qok) m_dout = sb.pop_front();
        if (pok) sb.push_back(d);
        if (pok && !qok) m_cnt++;
        else if (qok && !pok) m_cnt--;
        @(posedge clk);
        #1;
        bus.push = 1'b0;
        bus.pop = 1'b0;
        chk_state(vld);
    endtask

    initial begin
        reset = 1'b1;
        bus.push = 1'b0;
        bus.pop = 1'b0;
        bus.data_in = '0;

        // reset and idle
        do_reset(2, 1'b0, 1'b0);
        step(1'b0, 6'h00, 1'b0);

        // fill, overflow, drain
        step(1'b1, 6'h01, 1'b0);
        step(1'b1, 6'h02, 1'b0);
        step(1'b1, 6'h03, 1'b0);
        step(1'b1, 6'h04, 1'b0);
        step(1'b1, 6'h2A, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 6'h00, 1'b1);
        step(1'b0, 6'h00, 1'b0);

        // streaming at full across pointer wrap
        do_reset(1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 6'(8'h11 + i), 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, 6'(8'h05 + i), 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 6'h00, 1'b1);

        // underflow and push+pop on empty
        do_reset(1, 1'b0, 1'b0);
        step(1'b0, 6'h00, 1'b1);
        step(1'b1, 6'h1C, 1'b1);
        step(1'b0, 6'h00, 1'b1);

        // reset mid-operation with pop held
        do_reset(1, 1'b0, 1'b0);
        step(1'b1, 6'h21, 1'b0);
        step(1'b1, 6'h22, 1'b0);
        step(1'b1, 6'h23, 1'b0);
        do_reset(1, 1'b0, 1'b1);
        step(1'b1, 6'h33, 1'b0);
        step(1'b0, 6'h00, 1'b1);
        step(1'b0, 6'h00, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
